model_standard_linear_sequencer: RTL and testbench

Controller that sequences one evaluation of the standard linear state core (h = W·x + b form).
- Accepts an operand stream from an upstream requester and converts it into the core's element-wise load strobes for W (L×X), then b (L), then x (X).
- Pulses the core START, then forwards the core's L-element H output stream to a result port.
- Sits between the NTM controller datapath and the standard linear core; one sequencer per core.

---
 rtl/model_standard_linear_sequencer_if.sv | 43 ++++
 rtl/model_standard_linear_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_model_standard_linear_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/model_standard_linear_sequencer_if.sv
// Handshake and element-stream bundle between the requester, the sequencer and the linear core.
// master: requester/core side; slave: the sequencer itself.
interface model_standard_linear_sequencer_if #(
  parameter int unsigned DATA_SIZE = 64
);
  logic                 SEQ_START;
  logic                 SEQ_READY;
  logic                 SEQ_ERROR;
  logic [DATA_SIZE-1:0] SIZE_X_IN;
  logic [DATA_SIZE-1:0] SIZE_L_IN;
  logic [DATA_SIZE-1:0] OP_DATA;
  logic                 OP_VALID;
  logic                 OP_READY;
  logic [DATA_SIZE-1:0] RES_DATA;
  logic                 RES_VALID;
  logic                 CORE_START;
  logic                 CORE_READY;
  logic                 CORE_W_IN_L_ENABLE;
  logic                 CORE_W_IN_X_ENABLE;
  logic                 CORE_B_IN_ENABLE;
  logic                 CORE_X_IN_ENABLE;
  logic [DATA_SIZE-1:0] CORE_W_IN;
  logic [DATA_SIZE-1:0] CORE_B_IN;
  logic [DATA_SIZE-1:0] CORE_X_IN;
  logic                 CORE_H_OUT_ENABLE;
  logic [DATA_SIZE-1:0] CORE_H_OUT;

  modport master (
    output SEQ_START, SIZE_X_IN, SIZE_L_IN, OP_DATA, OP_VALID,
    output CORE_READY, CORE_H_OUT_ENABLE, CORE_H_OUT,
    input  SEQ_READY, SEQ_ERROR, OP_READY, RES_DATA, RES_VALID, CORE_START,
    input  CORE_W_IN_L_ENABLE, CORE_W_IN_X_ENABLE, CORE_B_IN_ENABLE, CORE_X_IN_ENABLE,
    input  CORE_W_IN, CORE_B_IN, CORE_X_IN
  );

  modport slave (
    input  SEQ_START, SIZE_X_IN, SIZE_L_IN, OP_DATA, OP_VALID,
    input  CORE_READY, CORE_H_OUT_ENABLE, CORE_H_OUT,
    output SEQ_READY, SEQ_ERROR, OP_READY, RES_DATA, RES_VALID, CORE_START,
    output CORE_W_IN_L_ENABLE, CORE_W_IN_X_ENABLE, CORE_B_IN_ENABLE, CORE_X_IN_ENABLE,
    output CORE_W_IN, CORE_B_IN, CORE_X_IN
  );
endinterface

// File: rtl/model_standard_linear_sequencer.sv
// Sequences one h = W*x + b evaluation: streams W, b, x into the core, starts it, forwards H.
// Optional RUN watchdog enabled by MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN.
module model_standard_linear_sequencer #(
  parameter int unsigned DATA_SIZE      = 64,
  parameter int unsigned CONTROL_SIZE   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic CLK,
  input logic RST,
  model_standard_linear_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StLoadW, StLoadB, StLoadX, StStart, StRun, StDone
  } state_e;

  localparam logic [DATA_SIZE-1:0] MaxDim =
    {{(DATA_SIZE-CONTROL_SIZE){1'b0}}, {CONTROL_SIZE{1'b1}}};
  localparam logic [CONTROL_SIZE-1:0] CtrlOne = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_l_q, size_l_d, size_x_q, size_x_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d, hcnt_q, hcnt_d;
  logic                    over_q, over_d, err_q, err_d;
  logic                    w_l_en_q, w_l_en_d, w_x_en_q, w_x_en_d;
  logic                    b_en_q, b_en_d, x_en_q, x_en_d;
  logic [DATA_SIZE-1:0]    w_in_q, w_in_d, b_in_q, b_in_d, x_in_q, x_in_d;
  logic [DATA_SIZE-1:0]    res_data_q, res_data_d;
  logic                    res_valid_q, res_valid_d, core_start_q, core_start_d;
  logic                    seq_ready_q, seq_ready_d, seq_error_q, seq_error_d;
  logic                    op_ready, op_xfer, size_bad;
  logic [CONTROL_SIZE-1:0] hcnt_final;
  logic                    over_final;
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
  logic [31:0]             run_cnt_q, run_cnt_d;
`endif

  assign op_ready = (state_q == StLoadW) || (state_q == StLoadB) || (state_q == StLoadX);
  assign op_xfer  = bus.OP_VALID && op_ready;
  assign size_bad = (bus.SIZE_L_IN == '0) || (bus.SIZE_X_IN == '0) ||
                    (bus.SIZE_L_IN > MaxDim) || (bus.SIZE_X_IN > MaxDim);

  // H element arriving together with CORE_READY still counts toward the final tally.
  assign hcnt_final = (bus.CORE_H_OUT_ENABLE && (hcnt_q != size_l_q)) ? hcnt_q + CtrlOne : hcnt_q;
  assign over_final = over_q || (bus.CORE_H_OUT_ENABLE && (hcnt_q == size_l_q));

  always_comb begin
    state_d      = state_q;
    size_l_d     = size_l_q;
    size_x_d     = size_x_q;
    i_d          = i_q;
    j_d          = j_q;
    hcnt_d       = hcnt_q;
    over_d       = over_q;
    err_d        = err_q;
    w_l_en_d     = 1'b0;
    w_x_en_d     = 1'b0;
    b_en_d       = 1'b0;
    x_en_d       = 1'b0;
    w_in_d       = w_in_q;
    b_in_d       = b_in_q;
    x_in_d       = x_in_q;
    res_data_d   = res_data_q;
    res_valid_d  = 1'b0;
    core_start_d = 1'b0;
    seq_ready_d  = 1'b0;
    seq_error_d  = 1'b0;
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
    run_cnt_d    = run_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.SEQ_START) begin
          if (size_bad) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            size_l_d = bus.SIZE_L_IN[CONTROL_SIZE-1:0];
            size_x_d = bus.SIZE_X_IN[CONTROL_SIZE-1:0];
            i_d      = '0;
            j_d      = '0;
            err_d    = 1'b0;
            state_d  = StLoadW;
          end
        end
      end
      StLoadW: begin
        if (op_xfer) begin
          w_x_en_d = 1'b1;
          w_l_en_d = (j_q == '0);
          w_in_d   = bus.OP_DATA;
          if (j_q == size_x_q - CtrlOne) begin
            j_d = '0;
            if (i_q == size_l_q - CtrlOne) begin
              i_d     = '0;
              state_d = StLoadB;
            end else begin
              i_d = i_q + CtrlOne;
            end
          end else begin
            j_d = j_q + CtrlOne;
          end
        end
      end
      StLoadB: begin
        if (op_xfer) begin
          b_en_d = 1'b1;
          b_in_d = bus.OP_DATA;
          if (i_q == size_l_q - CtrlOne) begin
            i_d     = '0;
            state_d = StLoadX;
          end else begin
            i_d = i_q + CtrlOne;
          end
        end
      end
      StLoadX: begin
        if (op_xfer) begin
          x_en_d = 1'b1;
          x_in_d = bus.OP_DATA;
          if (j_q == size_x_q - CtrlOne) begin
            j_d     = '0;
            state_d = StStart;
          end else begin
            j_d = j_q + CtrlOne;
          end
        end
      end
      StStart: begin
        core_start_d = 1'b1;
        hcnt_d       = '0;
        over_d       = 1'b0;
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
        run_cnt_d    = '0;
`endif
        state_d      = StRun;
      end
      StRun: begin
        if (bus.CORE_H_OUT_ENABLE) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.CORE_H_OUT;
        end
        hcnt_d = hcnt_final;
        over_d = over_final;
        if (bus.CORE_READY) begin
          err_d   = (hcnt_final != size_l_q) || over_final;
          state_d = StDone;
        end
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
        else if (run_cnt_q == TIMEOUT_CYCLES - 1) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          run_cnt_d = run_cnt_q + 32'd1;
        end
`endif
      end
      StDone: begin
        seq_ready_d = 1'b1;
        seq_error_d = err_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      size_l_q     <= '0;
      size_x_q     <= '0;
      i_q          <= '0;
      j_q          <= '0;
      hcnt_q       <= '0;
      over_q       <= 1'b0;
      err_q        <= 1'b0;
      w_l_en_q     <= 1'b0;
      w_x_en_q     <= 1'b0;
      b_en_q       <= 1'b0;
      x_en_q       <= 1'b0;
      w_in_q       <= '0;
      b_in_q       <= '0;
      x_in_q       <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      seq_ready_q  <= 1'b0;
      seq_error_q  <= 1'b0;
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
      run_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      size_l_q     <= size_l_d;
      size_x_q     <= size_x_d;
      i_q          <= i_d;
      j_q          <= j_d;
      hcnt_q       <= hcnt_d;
      over_q       <= over_d;
      err_q        <= err_d;
      w_l_en_q     <= w_l_en_d;
      w_x_en_q     <= w_x_en_d;
      b_en_q       <= b_en_d;
      x_en_q       <= x_en_d;
      w_in_q       <= w_in_d;
      b_in_q       <= b_in_d;
      x_in_q       <= x_in_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      core_start_q <= core_start_d;
      seq_ready_q  <= seq_ready_d;
      seq_error_q  <= seq_error_d;
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
      run_cnt_q    <= run_cnt_d;
`endif
    end
  end

  assign bus.OP_READY           = op_ready;
  assign bus.SEQ_READY          = seq_ready_q;
  assign bus.SEQ_ERROR          = seq_error_q;
  assign bus.RES_DATA           = res_data_q;
  assign bus.RES_VALID          = res_valid_q;
  assign bus.CORE_START         = core_start_q;
  assign bus.CORE_W_IN_L_ENABLE = w_l_en_q;
  assign bus.CORE_W_IN_X_ENABLE = w_x_en_q;
  assign bus.CORE_B_IN_ENABLE   = b_en_q;
  assign bus.CORE_X_IN_ENABLE   = x_en_q;
  assign bus.CORE_W_IN          = w_in_q;
  assign bus.CORE_B_IN          = b_in_q;
  assign bus.CORE_X_IN          = x_in_q;

endmodule

// File: tb/tb_model_standard_linear_sequencer.sv
// Scoreboard bench: load strobes and results are predicted from the driven stimulus.
module tb_model_standard_linear_sequencer;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  model_standard_linear_sequencer_if #(.DATA_SIZE(DW)) bus ();

  model_standard_linear_sequencer #(
    .DATA_SIZE(DW), .CONTROL_SIZE(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  typedef struct {
    logic [2:0]    kind;   // {x, b, w}
    logic [DW-1:0] data;
    logic          lflag;
    logic          last;
  } item_t;

  item_t         op_q[$];
  logic [DW-1:0] res_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cfg_l, cfg_x, mon_k;
  logic          start_arm  = 1'b0;
  logic          seen_start = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pops predictions for strobes/results, then pushes a prediction for this cycle's transfer.
  always @(negedge CLK) begin
    item_t it;
    logic  exp_start;
    logic [DW-1:0] obs_data;
    exp_start = start_arm;
    start_arm = 1'b0;
    if (bus.CORE_W_IN_X_ENABLE || bus.CORE_B_IN_ENABLE || bus.CORE_X_IN_ENABLE ||
        bus.CORE_W_IN_L_ENABLE) begin
      if (op_q.size() == 0) begin
        check_eq("spurious_strobe", 64'd1, 64'd0);
      end else begin
        it = op_q.pop_front();
        check_eq("strobe_kind",
                 {61'd0, bus.CORE_X_IN_ENABLE, bus.CORE_B_IN_ENABLE, bus.CORE_W_IN_X_ENABLE},
                 {61'd0, it.kind});
        obs_data = it.kind[0] ? bus.CORE_W_IN : (it.kind[1] ? bus.CORE_B_IN : bus.CORE_X_IN);
        check_eq("strobe_data", obs_data, it.data);
        check_eq("w_l_enable", {63'd0, bus.CORE_W_IN_L_ENABLE}, {63'd0, it.lflag});
        if (it.last) start_arm = 1'b1;
      end
    end
    if (bus.CORE_START || exp_start)
      check_eq("core_start", {63'd0, bus.CORE_START}, {63'd0, exp_start});
    if (bus.CORE_START) seen_start = 1'b1;
    if (bus.RES_VALID) begin
      if (res_q.size() == 0) check_eq("spurious_result", 64'd1, 64'd0);
      else check_eq("res_data", bus.RES_DATA, res_q.pop_front());
    end
    if (RST) begin
      op_q.delete();
      res_q.delete();
      start_arm = 1'b0;
    end else if (bus.OP_VALID && bus.OP_READY) begin
      if (mon_k < cfg_l * cfg_x) begin
        it.kind  = 3'b001;
        it.lflag = ((mon_k % cfg_x) == 0);
      end else if (mon_k < cfg_l * cfg_x + cfg_l) begin
        it.kind  = 3'b010;
        it.lflag = 1'b0;
      end else begin
        it.kind  = 3'b100;
        it.lflag = 1'b0;
      end
      it.data = DW'(mon_k + 1);
      it.last = (mon_k == cfg_l * cfg_x + cfg_l + cfg_x - 1);
      op_q.push_back(it);
      mon_k++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge CLK);
    check_eq({tag, "_flags"},
             {55'd0, bus.SEQ_READY, bus.SEQ_ERROR, bus.OP_READY, bus.RES_VALID, bus.CORE_START,
              bus.CORE_W_IN_L_ENABLE, bus.CORE_W_IN_X_ENABLE, bus.CORE_B_IN_ENABLE,
              bus.CORE_X_IN_ENABLE}, 64'd0);
    check_eq({tag, "_res_data"}, bus.RES_DATA, 64'd0);
    check_eq({tag, "_w_in"}, bus.CORE_W_IN, 64'd0);
    check_eq({tag, "_b_in"}, bus.CORE_B_IN, 64'd0);
    check_eq({tag, "_x_in"}, bus.CORE_X_IN, 64'd0);
    tick();
  endtask

  task automatic start_seq(input int l, input int x);
    cfg_l = l;
    cfg_x = x;
    mon_k = 0;
    seen_start = 1'b0;
    bus.SIZE_L_IN = DW'(l);
    bus.SIZE_X_IN = DW'(x);
    bus.SEQ_START = 1'b1;
    tick();
    bus.SEQ_START = 1'b0;
  endtask

  task automatic feed(input int stop_at, input bit toggle);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < stop_at && guard < 500) begin
      bus.OP_VALID = toggle ? ((guard % 2) == 0) : 1'b1;
      bus.OP_DATA  = DW'(k + 1);
      @(negedge CLK);
      acc = bus.OP_VALID && bus.OP_READY;
      tick();
      if (acc) k++;
      guard++;
    end
    bus.OP_VALID = 1'b0;
    if (guard >= 500) check_eq("feed_timeout", DW'(k), DW'(stop_at));
  endtask

  task automatic wait_start();
    int g = 0;
    while (!seen_start && g < 200) begin
      @(negedge CLK);
      g++;
    end
    if (!seen_start) check_eq("start_timeout", 64'd0, 64'd1);
    seen_start = 1'b0;
  endtask

  task automatic wait_seq_ready(input int max, output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!bus.SEQ_READY && lat < max);
  endtask

  task automatic run_case(input string name, input int l, input int x, input bit tog,
                          input int n_h, input bit coinc, input bit exp_err);
    int lat;
    start_seq(l, x);
    feed(l * x + l + x, tog);
    wait_start();
    tick();
    for (int i = 0; i < n_h; i++) begin
      bus.CORE_H_OUT_ENABLE = 1'b1;
      bus.CORE_H_OUT        = DW'(32'hA0 + i);
      res_q.push_back(DW'(32'hA0 + i));
      bus.CORE_READY        = coinc && (i == n_h - 1);
      tick();
    end
    bus.CORE_H_OUT_ENABLE = 1'b0;
    if (!coinc || n_h == 0) begin
      bus.CORE_READY = 1'b1;
      tick();
    end
    bus.CORE_READY = 1'b0;
    wait_seq_ready(20, lat);
    check_eq({name, "_ready_latency"}, DW'(lat), 64'd2);
    check_eq({name, "_seq_error"}, {63'd0, bus.SEQ_ERROR}, {63'd0, exp_err});
    @(negedge CLK);
    check_eq({name, "_ready_pulse"}, {63'd0, bus.SEQ_READY}, 64'd0);
    check_eq({name, "_op_q_empty"}, DW'(op_q.size()), 64'd0);
    check_eq({name, "_res_q_empty"}, DW'(res_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int lat;
    bus.SEQ_START = 1'b0;
    bus.SIZE_X_IN = '0;
    bus.SIZE_L_IN = '0;
    bus.OP_DATA = '0;
    bus.OP_VALID = 1'b0;
    bus.CORE_READY = 1'b0;
    bus.CORE_H_OUT_ENABLE = 1'b0;
    bus.CORE_H_OUT = '0;
    cfg_l = 0;
    cfg_x = 1;
    mon_k = 0;
    RST = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    RST = 1'b0;
    tick();

    run_case("basic", 2, 3, 1'b0, 2, 1'b0, 1'b0);
    run_case("toggle", 2, 3, 1'b1, 2, 1'b0, 1'b0);
    run_case("short_h", 2, 3, 1'b0, 1, 1'b0, 1'b1);
    run_case("coincident", 2, 3, 1'b0, 2, 1'b1, 1'b0);
    run_case("extra_h", 2, 3, 1'b0, 3, 1'b0, 1'b1);
    run_case("max_dim", 15, 1, 1'b1, 15, 1'b1, 1'b0);

    // Degenerate and oversized dimensions never touch the core.
    start_seq(0, 3);
    wait_seq_ready(20, lat);
    check_eq("zero_l_latency", DW'(lat), 64'd2);
    check_eq("zero_l_error", {63'd0, bus.SEQ_ERROR}, 64'd1);
    start_seq(3, 16);
    wait_seq_ready(20, lat);
    check_eq("big_x_latency", DW'(lat), 64'd2);
    check_eq("big_x_error", {63'd0, bus.SEQ_ERROR}, 64'd1);
    repeat (4) tick();

    // Reset in the middle of the b load.
    start_seq(2, 3);
    feed(7, 1'b0);
    RST = 1'b1;
    tick();
    check_all_zero("mid_reset");
    RST = 1'b0;
    repeat (3) tick();
    run_case("after_reset", 2, 3, 1'b0, 2, 1'b0, 1'b0);

    // Core never answers.
    start_seq(2, 3);
    feed(11, 1'b0);
    wait_start();
    wait_seq_ready(40, lat);
`ifdef MODEL_STANDARD_LINEAR_SEQUENCER_TIMEOUT_EN
    check_eq("timeout_latency", DW'(lat), 64'd17);
    check_eq("timeout_error", {63'd0, bus.SEQ_ERROR}, 64'd1);
`else
    check_eq("no_timeout", {63'd0, bus.SEQ_READY}, 64'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
`endif
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
